// File: rtl/localbus_arbiter_dec.sv
// -----------------------------------------------------------------------------
// localbus_arbiter_dec
// Decodes the master's LocalBus address against NSLV base/mask windows and
// runs one transaction at a time to the selected slave. A transaction has a
// ready handshake, slave wait states, a timeout and a decode-error response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i               master request; addr/qin/we held stable until ready
//   addr_i, qin_i, we_i master address, write data, byte enables (0 = read)
//   qout_o              read data, valid while ready_o=1
//   ready_o             one-cycle completion pulse
//   err_o               error response, valid while ready_o=1
//   s_sel_o             one-hot slave select (ACCESS only)
//   s_addr_o, s_wdata_o latched address / write data shared by all slaves
//   s_we_o              per-slave byte enables, pulsed on first ACCESS cycle
//   s_rdata_i           per-slave read data
//   s_ready_i           per-slave completion
//
// Optional error log (define LOCALBUS_ERRLOG_EN):
//   err_clr_i           clears the log
//   err_addr_o          address of the last error response
//   err_code_o          2'b01 decode error, 2'b10 timeout
// -----------------------------------------------------------------------------
module localbus_arbiter_dec #(
    parameter int unsigned              XLEN     = 32,
    parameter int unsigned              NSLV     = 5,
    parameter logic [NSLV*XLEN-1:0]     SLV_BASE = {32'h0400_0000, 32'h0300_0000,
                                                    32'h0200_0000, 32'h0100_0000,
                                                    32'h0000_0000},
    parameter logic [NSLV*XLEN-1:0]     SLV_MASK = {NSLV{32'hFF00_0000}},
    parameter int unsigned              TIMEOUT  = 255,
    parameter int unsigned              TW       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef LOCALBUS_ERRLOG_EN
    input  logic                 err_clr_i,
    output logic [XLEN-1:0]      err_addr_o,
    output logic [1:0]           err_code_o,
`endif
    input  logic                 req_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      qin_i,
    input  logic [3:0]           we_i,
    output logic [XLEN-1:0]      qout_o,
    output logic                 ready_o,
    output logic                 err_o,
    output logic [NSLV-1:0]      s_sel_o,
    output logic [XLEN-1:0]      s_addr_o,
    output logic [XLEN-1:0]      s_wdata_o,
    output logic [4*NSLV-1:0]    s_we_o,
    input  logic [NSLV*XLEN-1:0] s_rdata_i,
    input  logic [NSLV-1:0]      s_ready_i
);

    localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      we_q, we_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] qout_q, qout_d;
    logic            err_q, err_d;

    logic            hit_any;
    logic [IW-1:0]   hit_idx;
    logic            sel_ready;
    logic [XLEN-1:0] sel_rdata;
    logic            to_hit;
    logic            log_dec;
    logic            log_to;

    // Priority decode: scanning from the top down lets the lowest index win.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[i*XLEN +: XLEN]) ==
                (SLV_BASE[i*XLEN +: XLEN] & SLV_MASK[i*XLEN +: XLEN])) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign sel_ready = s_ready_i[idx_q];
    assign sel_rdata = s_rdata_i[idx_q*XLEN +: XLEN];
    assign to_hit    = (cnt_q == TW'(TIMEOUT));

    // Error events, taken on the edge that enters RESP with err=1.
    assign log_dec = (state_q == StIdle) && req_i && !hit_any;
    assign log_to  = (state_q == StAccess) && !sel_ready && to_hit;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        qout_d  = qout_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = qin_i;
                    we_d    = we_i;
                    idx_d   = hit_idx;
                    cnt_d   = '0;
                    if (hit_any) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        qout_d  = '0;
                    end
                end
            end
            StAccess: begin
                if (sel_ready) begin
                    // Writes return zero data.
                    qout_d  = (we_q != 4'b0000) ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (to_hit) begin
                    qout_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            qout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state so an async reset drops them at once.
    // cnt_q is zero only on the first ACCESS cycle, giving a single write strobe.
    always_comb begin
        s_sel_o = '0;
        s_we_o  = '0;
        if (state_q == StAccess) begin
            s_sel_o[idx_q] = 1'b1;
            if (cnt_q == '0) begin
                s_we_o[idx_q*4 +: 4] = we_q;
            end
        end
    end

    assign ready_o   = (state_q == StResp);
    assign err_o     = (state_q == StResp) && err_q;
    assign qout_o    = qout_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;

`ifdef LOCALBUS_ERRLOG_EN
    logic [XLEN-1:0] err_addr_q;
    logic [1:0]      err_code_q;

    // A new error takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q <= '0;
            err_code_q <= 2'b00;
        end else if (log_dec) begin
            err_addr_q <= addr_i;
            err_code_q <= 2'b01;
        end else if (log_to) begin
            err_addr_q <= addr_q;
            err_code_q <= 2'b10;
        end else if (err_clr_i) begin
            err_addr_q <= '0;
            err_code_q <= 2'b00;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_code_o = err_code_q;
`else
    logic unused_log;
    assign unused_log = log_dec ^ log_to;
`endif

endmodule

// File: tb/tb_localbus_arbiter_dec.sv
module tb_localbus_arbiter_dec;

    localparam int XLEN = 32;
    localparam int NSLV = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req = 1'b0;
    logic [XLEN-1:0]      addr = '0;
    logic [XLEN-1:0]      qin = '0;
    logic [3:0]           we = '0;
    logic [XLEN-1:0]      qout;
    logic                 ready;
    logic                 err;
    logic [NSLV-1:0]      s_sel;
    logic [XLEN-1:0]      s_addr;
    logic [XLEN-1:0]      s_wdata;
    logic [4*NSLV-1:0]    s_we;
    logic [NSLV*XLEN-1:0] s_rdata = '0;
    logic [NSLV-1:0]      s_ready = '0;
`ifdef LOCALBUS_ERRLOG_EN
    logic                 err_clr = 1'b0;
    logic [XLEN-1:0]      err_addr;
    logic [1:0]           err_code;
`endif

    always #5 clk = ~clk;

    localbus_arbiter_dec dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LOCALBUS_ERRLOG_EN
        .err_clr_i  (err_clr),
        .err_addr_o (err_addr),
        .err_code_o (err_code),
`endif
        .req_i      (req),
        .addr_i     (addr),
        .qin_i      (qin),
        .we_i       (we),
        .qout_o     (qout),
        .ready_o    (ready),
        .err_o      (err),
        .s_sel_o    (s_sel),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_we_o     (s_we),
        .s_rdata_i  (s_rdata),
        .s_ready_i  (s_ready)
    );

    typedef struct {
        logic [31:0] qout;
        logic        err;
        int          lat;
        logic [4:0]  sel;
        logic [19:0] swe;
        int          sel_cyc;
        int          we_cyc;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [1:0]  code;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: unselected slaves always claim ready (must be ignored);
    // the selected one answers after slv_wait not-ready cycles (-1 = never).
    int slv_wait = 0;
    int acc_cyc = 0;
    always @(negedge clk) begin
        if (s_sel != '0) begin
            s_ready = ~s_sel;
            if (slv_wait >= 0 && acc_cyc >= slv_wait) s_ready = '1;
            acc_cyc++;
        end else begin
            s_ready = '0;
            acc_cyc = 0;
        end
    end

    // Monitor: tracks strobes per transaction and checks each ready pulse.
    logic       busy = 1'b0;
    int         lat = 0;
    int         sel_cyc = 0;
    int         we_cyc = 0;
    logic [4:0] sel_seen = '0;
    logic [19:0] we_seen = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                lat++;
            end else if (req) begin
                busy = 1'b1;
                lat = 0;
                sel_cyc = 0;
                we_cyc = 0;
                sel_seen = '0;
                we_seen = '0;
            end
            if (s_sel != '0) begin
                sel_cyc++;
                sel_seen |= s_sel;
            end
            if (s_we != '0) begin
                we_cyc++;
                we_seen |= s_we;
            end
            if (ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1, expected no response");
                end else begin
                    e = sb.pop_front();
                    check("qout", qout, e.qout);
                    check("err", err, e.err);
                    check("latency", lat, e.lat);
                    check("s_sel_seen", sel_seen, e.sel);
                    check("s_we_seen", we_seen, e.swe);
                    check("s_sel_cycles", sel_cyc, e.sel_cyc);
                    check("s_we_pulses", we_cyc, e.we_cyc);
                    check("s_addr", s_addr, e.saddr);
                    check("s_wdata", s_wdata, e.swdata);
`ifdef LOCALBUS_ERRLOG_EN
                    check("err_code", err_code, e.code);
                    check("err_addr", err_addr, e.eaddr);
`endif
                end
                busy = 1'b0;
            end
        end
    end

    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       input int wt, input int slv, input logic [31:0] rd,
                       input logic [31:0] eq, input logic ee, input int elat,
                       input logic [4:0] esel, input logic [19:0] ewe, input int esc,
                       input int ewc, input logic [1:0] ecode, input logic [31:0] eaddr);
        exp_t e;
        int   n;
        e.qout = eq; e.err = ee; e.lat = elat; e.sel = esel; e.swe = ewe;
        e.sel_cyc = esc; e.we_cyc = ewc; e.saddr = a; e.swdata = d;
        e.code = ecode; e.eaddr = eaddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        for (int i = 0; i < NSLV; i++) s_rdata[i*XLEN +: XLEN] = 32'hBAD0_0000 | i;
        if (slv >= 0) s_rdata[slv*XLEN +: XLEN] = rd;
        slv_wait = wt;
        addr = a;
        qin = d;
        we = w;
        req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 400);
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready in %0d cycles, expected ready", n);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        we = '0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_qout", qout, 32'h0);
        check("rst_s_sel", s_sel, 5'h0);
        check("rst_s_we", s_we, 20'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_wdata", s_wdata, 32'h0);
`ifdef LOCALBUS_ERRLOG_EN
        check("rst_err_code", err_code, 2'b00);
        check("rst_err_addr", err_addr, 32'h0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // RAM read, immediate response
        txn(32'h0000_0010, 32'h0, 4'b0000, 0, 0, 32'hDEAD_BEEF,
            32'hDEAD_BEEF, 1'b0, 2, 5'b00001, 20'h0, 1, 0, 2'b00, 32'h0);
        // GPIO byte write
        txn(32'h0100_0004, 32'h0000_AB00, 4'b0010, 0, 1, 32'h1234_5678,
            32'h0, 1'b0, 2, 5'b00010, 20'h00020, 1, 1, 2'b00, 32'h0);
        // UART word write with 7 wait cycles
        txn(32'h0400_0100, 32'hCAFE_F00D, 4'b1111, 7, 4, 32'h5555_AAAA,
            32'h0, 1'b0, 9, 5'b10000, 20'hF0000, 8, 1, 2'b00, 32'h0);
        // VGA read with 2 wait cycles
        txn(32'h0200_0040, 32'h0, 4'b0000, 2, 2, 32'h0BAD_CAFE,
            32'h0BAD_CAFE, 1'b0, 4, 5'b00100, 20'h0, 3, 0, 2'b00, 32'h0);
        // VGA never answers: timeout after 256 ACCESS cycles
        txn(32'h0200_0080, 32'h1111_2222, 4'b0000, -1, 2, 32'h7777_7777,
            32'h0, 1'b1, 257, 5'b00100, 20'h0, 256, 0, 2'b10, 32'h0200_0080);
        // Timer read with 1 wait cycle
        txn(32'h0300_0000, 32'h0, 4'b0000, 1, 3, 32'h3333_0003,
            32'h3333_0003, 1'b0, 3, 5'b01000, 20'h0, 2, 0, 2'b10, 32'h0200_0080);
        // Decode error (write attempt, no strobe); clear held high, log still wins
`ifdef LOCALBUS_ERRLOG_EN
        err_clr = 1'b1;
`endif
        txn(32'h0F00_0000, 32'h9999_0000, 4'b0100, 0, -1, 32'h0,
            32'h0, 1'b1, 1, 5'b00000, 20'h0, 0, 0, 2'b01, 32'h0F00_0000);
`ifdef LOCALBUS_ERRLOG_EN
        #1;
        check("clr_err_code", err_code, 2'b00);
        check("clr_err_addr", err_addr, 32'h0);
        err_clr = 1'b0;
`endif

        // Reset during the 3rd wait cycle of a UART write
        @(posedge clk);
        #1;
        slv_wait = -1;
        addr = 32'h0400_0000;
        qin = 32'hABCD_0000;
        we = 4'b1111;
        req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_s_sel", s_sel, 5'b10000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_sel", s_sel, 5'h0);
        check("mid_rst_s_we", s_we, 20'h0);
        check("mid_rst_ready", ready, 1'b0);
        check("mid_rst_s_addr", s_addr, 32'h0);
        check("mid_rst_s_wdata", s_wdata, 32'h0);
        req = 1'b0;
        we = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Normal RAM read after reset
        txn(32'h0000_0100, 32'h0, 4'b0000, 0, 0, 32'h600D_F00D,
            32'h600D_F00D, 1'b0, 2, 5'b00001, 20'h0, 1, 0, 2'b00, 32'h0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
